// File: rtl/ghash_pkg.sv
// rtl/ghash_pkg.sv - shared constants, state encoding and bit helpers for the GHASH byte multiplier
// Contents: element/byte/table-entry widths, the reduction constant R_X,
// the FSM state encoding, and bit_rev_byte() used to form the reduction-table index.
package ghash_pkg;

  localparam int NB_BLOCK   = 128;
  localparam int NB_BYTE    = 8;
  localparam int NB_R_ENTRY = 16;

  // x^128 = 1 + x + x^2 + x^7, placed at the x^0..x^7 end of the vector (bits [127:120])
  localparam logic [NB_BYTE-1:0] R_X = 8'hE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_MULT = 2'd2
  } state_e;

  function automatic logic [NB_BYTE-1:0] bit_rev_byte(input logic [NB_BYTE-1:0] b);
    logic [NB_BYTE-1:0] r;
    for (int i = 0; i < NB_BYTE; i++) begin
      r[i] = b[NB_BYTE-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ghash_byte_times_h.sv
// rtl/ghash_byte_times_h.sv - combinational product of one operand byte with H
// Ports:
//   i_byte  - operand byte; bit 7 is the lowest-degree coefficient (GCM bit order)
//   i_hpow  - H*x^j for j = 0..7
//   o_bh    - XOR of H*x^j over every j with i_byte[7-j] set
module ghash_byte_times_h
  import ghash_pkg::*;
(
  input  logic [NB_BYTE-1:0]               i_byte,
  input  logic [NB_BYTE-1:0][NB_BLOCK-1:0] i_hpow,
  output logic [NB_BLOCK-1:0]              o_bh
);

  always_comb begin
    o_bh = '0;
    for (int j = 0; j < NB_BYTE; j++) begin
      if (i_byte[NB_BYTE-1-j]) begin
        o_bh = o_bh ^ i_hpow[j];
      end
    end
  end

endmodule

// File: rtl/ghash_byte_multiplier.sv
// rtl/ghash_byte_multiplier.sv - sequential GF(2^128) multiplier, one operand byte per cycle
// Optional feature macro: GHASH_BYTE_MULT_ACCUM_EN (adds i_accumulate for GHASH chaining).
// Ports:
//   i_clock, i_reset  - clock and synchronous active-high reset
//   i_r_table         - 256 x 16-bit reduction table, entry k at [k*16+:16]
//   i_h_key/i_h_valid - hash subkey load (8 cycles until o_ready again)
//   i_data/i_valid    - operand X; accepted only while o_ready
//   i_accumulate      - (feature build only) X = i_data ^ o_result
//   o_ready           - idle, a key or operand can be accepted
//   o_result/o_valid  - X*H, with a one-cycle o_valid pulse 17 cycles after acceptance
module ghash_byte_multiplier
  import ghash_pkg::*;
(
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic [256*NB_R_ENTRY-1:0]        i_r_table,
  input  logic [NB_BLOCK-1:0]              i_h_key,
  input  logic                             i_h_valid,
  input  logic [NB_BLOCK-1:0]              i_data,
  input  logic                             i_valid,
`ifdef GHASH_BYTE_MULT_ACCUM_EN
  input  logic                             i_accumulate,
`endif
  output logic                             o_ready,
  output logic [NB_BLOCK-1:0]              o_result,
  output logic                             o_valid
);

  state_e                          state_q, state_d;
  logic [3:0]                      cnt_q;
  logic [NB_BYTE-1:0][NB_BLOCK-1:0] hpow_q;
  logic [NB_BLOCK-1:0]             x_q;
  logic [NB_BLOCK-1:0]             z_q;
  logic [NB_BLOCK-1:0]             result_q;
  logic                            valid_q;

  logic [NB_BLOCK-1:0]             x_in;
  logic [NB_BLOCK-1:0]             hpow_prev;
  logic [NB_BLOCK-1:0]             hpow_next;
  logic [3:0]                      byte_idx;
  logic [NB_BYTE-1:0]              x_byte;
  logic [NB_BYTE-1:0]              r_idx;
  logic [NB_R_ENTRY-1:0]           r_entry;
  logic [NB_BLOCK-1:0]             bh;
  logic [NB_BLOCK-1:0]             z_next;

`ifdef GHASH_BYTE_MULT_ACCUM_EN
  assign x_in = i_accumulate ? (i_data ^ result_q) : i_data;
`else
  assign x_in = i_data;
`endif

  // Multiply by x: shift toward higher degree; x^127 falls off into x^128 and is folded back
  assign hpow_prev = hpow_q[cnt_q[2:0] - 3'd1];
  assign hpow_next = {1'b0, hpow_prev[NB_BLOCK-1:1]}
                   ^ (hpow_prev[0] ? {R_X, {(NB_BLOCK-NB_BYTE){1'b0}}} : '0);

  // cnt counts 15 down to 0, so its complement walks vector bytes 0 (highest degree) to 15
  assign byte_idx = ~cnt_q;
  assign x_byte   = x_q[int'(byte_idx)*NB_BYTE +: NB_BYTE];

  // Z[7:0] holds x^120..x^127; after the x^8 shift they become x^128..x^135, Z[7] lowest
  assign r_idx   = bit_rev_byte(z_q[NB_BYTE-1:0]);
  assign r_entry = i_r_table[int'(r_idx)*NB_R_ENTRY +: NB_R_ENTRY];

  ghash_byte_times_h u_times_h (
    .i_byte (x_byte),
    .i_hpow (hpow_q),
    .o_bh   (bh)
  );

  assign z_next = {{NB_BYTE{1'b0}}, z_q[NB_BLOCK-1:NB_BYTE]}
                ^ {r_entry, {(NB_BLOCK-NB_R_ENTRY){1'b0}}}
                ^ bh;

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; key load wins over a simultaneous operand
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_h_valid) begin
          state_d = ST_KEY;
        end else if (i_valid) begin
          state_d = ST_MULT;
        end
      end
      ST_KEY: begin
        if (cnt_q == 4'd7) begin
          state_d = ST_IDLE;
        end
      end
      ST_MULT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_ready  = (state_q == ST_IDLE);
    o_result = result_q;
    o_valid  = valid_q;
  end

  // Datapath
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q    <= '0;
      hpow_q   <= '0;
      x_q      <= '0;
      z_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_h_valid) begin
            hpow_q[0] <= i_h_key;
            cnt_q     <= 4'd1;
          end else if (i_valid) begin
            x_q   <= x_in;
            z_q   <= '0;
            cnt_q <= 4'd15;
          end
        end
        ST_KEY: begin
          hpow_q[cnt_q[2:0]] <= hpow_next;
          cnt_q              <= cnt_q + 4'd1;
        end
        ST_MULT: begin
          z_q   <= z_next;
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            result_q <= z_next;
            valid_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ghash_byte_multiplier.sv
// tb/tb_ghash_byte_multiplier.sv - directed self-checking bench for ghash_byte_multiplier
module tb_ghash_byte_multiplier;

  localparam logic [127:0] C_OP   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] H_GCM  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] P_GCM  = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [127:0] ONE    = 128'h80000000_00000000_00000000_00000000;
  localparam logic [127:0] XPOLY  = 128'h40000000_00000000_00000000_00000000;
  localparam logic [127:0] X127   = 128'h00000000_00000000_00000000_00000001;
  localparam logic [127:0] RED    = 128'hE1000000_00000000_00000000_00000000;

  logic           clk = 1'b0;
  logic           rst;
  logic [4095:0]  r_table;
  logic [127:0]   h_key;
  logic           h_valid;
  logic [127:0]   data;
  logic           valid;
  logic           acc;
  logic           ready;
  logic [127:0]   result;
  logic           ovalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ghash_byte_multiplier dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_r_table    (r_table),
    .i_h_key      (h_key),
    .i_h_valid    (h_valid),
    .i_data       (data),
    .i_valid      (valid),
`ifdef GHASH_BYTE_MULT_ACCUM_EN
    .i_accumulate (acc),
`endif
    .o_ready      (ready),
    .o_result     (result),
    .o_valid      (ovalid)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check_eq({tag, " ready timeout"}, 128'(ready), 128'(1));
  endtask

  // Drives a key load; optionally also raises i_valid in the same cycle
  task automatic load_key(input logic [127:0] k, input logic with_op, input string tag);
    int lows = 0;
    wait_ready(tag);
    h_key = k; h_valid = 1'b1; valid = with_op; data = C_OP;
    @(negedge clk);
    h_valid = 1'b0; valid = 1'b0;
    while (!ready && lows < 40) begin
      lows++;
      @(negedge clk);
    end
    check_eq({tag, " ready_low"}, 128'(lows), 128'(7));
  endtask

  task automatic send_op(input logic [127:0] x, input logic a);
    data = x; valid = 1'b1; acc = a;
    @(negedge clk);
    valid = 1'b0; acc = 1'b0;
  endtask

  // Called one negedge after acceptance; a noise i_valid pulse may be driven mid-multiply
  task automatic wait_result(input string tag, input logic [127:0] exp, input logic noise);
    int n = 1;
    while (!ovalid && n < 40) begin
      valid = noise && (n == 5);
      if (valid) data = ~C_OP;
      @(negedge clk);
      n++;
    end
    valid = 1'b0;
    check_eq({tag, " latency"}, 128'(n), 128'(17));
    check_eq({tag, " result"}, result, exp);
  endtask

  task automatic count_valid(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ovalid) seen++;
    end
    check_eq({tag, " no_valid"}, 128'(seen), 128'(0));
  endtask

  initial begin
    logic [15:0] e;
    for (int k = 0; k < 256; k++) begin
      e = 16'h0;
      for (int i = 0; i < 8; i++) begin
        if (k[i]) e = e ^ (16'hE100 >> i);
      end
      r_table[k*16 +: 16] = e;
    end

    rst = 1'b1; h_key = '0; h_valid = 1'b0; data = '0; valid = 1'b0; acc = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("reset ready", 128'(ready), 128'(1));
    check_eq("reset valid", 128'(ovalid), 128'(0));
    check_eq("reset result", result, 128'h0);

    send_op(C_OP, 1'b0);
    wait_result("nokey", 128'h0, 1'b0);

    load_key(ONE, 1'b0, "key_one");
    wait_ready("ident");
    send_op(C_OP, 1'b0);
    wait_result("ident", C_OP, 1'b0);

    load_key(XPOLY, 1'b0, "key_x");
    wait_ready("reduce");
    send_op(X127, 1'b0);
    wait_result("reduce", RED, 1'b0);

    load_key(H_GCM, 1'b0, "key_gcm");
    wait_ready("gcm");
    send_op(C_OP, 1'b0);
    wait_result("gcm", P_GCM, 1'b1);
    send_op(ONE, 1'b0);
    wait_result("b2b", H_GCM, 1'b0);
    count_valid("after_b2b", 25);

    load_key(ONE, 1'b1, "key_and_op");
    count_valid("key_and_op", 25);
    wait_ready("key1_mult");
    send_op(P_GCM, 1'b0);
    wait_result("key1_mult", P_GCM, 1'b0);

    send_op(C_OP, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst ready", 128'(ready), 128'(1));
    check_eq("midrst valid", 128'(ovalid), 128'(0));
    check_eq("midrst result", result, 128'h0);
    count_valid("midrst", 20);
    send_op(C_OP, 1'b0);
    wait_result("postrst", 128'h0, 1'b0);

`ifdef GHASH_BYTE_MULT_ACCUM_EN
    load_key(ONE, 1'b0, "acc_key");
    wait_ready("acc1");
    send_op(128'h0F, 1'b0);
    wait_result("acc1", 128'h0F, 1'b0);
    send_op(128'hF0, 1'b1);
    wait_result("acc2", 128'hFF, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
